// File: rtl/demux_reg_2sh.sv
// -----------------------------------------------------------------------------
// demux_reg_2sh
//
// Registered 2-share demultiplexer for the threshold-implementation PRINCE
// datapath. One masked word (shares in1/in2) is accepted per valid/ready
// handshake and steered to destination A (sel = 0) or B (sel = 1). Each
// destination owns a one-entry output register with its own valid/ready
// handshake, so A and B drain independently of each other.
//
// The two shares of a word live in separate registers and travel through
// separate logic cones. No signal ever combines share 1 with share 2.
//
// Optional feature macro: DEMUX_REFRESH_EN
//   When defined, a fresh random word rnd is XORed into both shares on the
//   accepting edge (share1 ^ rnd, share2 ^ rnd). The unmasked value is kept,
//   and each XOR touches only one share. When undefined, the rnd port does
//   not exist and the shares are loaded unmodified.
//
// Parameters:
//   N         datapath width per share in bits (default 64)
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   in_valid  input word present
//   in_ready  block can accept the input word this cycle (combinational)
//   sel       destination select, sampled only on acceptance
//   in1/in2   share 1 / share 2 of the input word
//   a_valid   slot A holds a word
//   a_ready   consumer A takes the word
//   a1/a2     share 1 / share 2 held in slot A
//   b_valid   slot B holds a word
//   b_ready   consumer B takes the word
//   b1/b2     share 1 / share 2 held in slot B
//   rnd       fresh randomness (only with DEMUX_REFRESH_EN)
// -----------------------------------------------------------------------------
module demux_reg_2sh #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sel,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [N-1:0] a1,
    output logic [N-1:0] a2,
    output logic         b_valid,
    input  logic         b_ready,
    output logic [N-1:0] b1,
    output logic [N-1:0] b2
`ifdef DEMUX_REFRESH_EN
    ,
    input  logic [N-1:0] rnd
`endif
);

    // Per-slot state: one valid flag plus two share registers each.
    logic         a_valid_q, a_valid_d;
    logic         b_valid_q, b_valid_d;
    logic [N-1:0] a1_q, a1_d;
    logic [N-1:0] a2_q, a2_d;
    logic [N-1:0] b1_q, b1_d;
    logic [N-1:0] b2_q, b2_d;

    // Handshake helpers.
    logic         a_can_take_s;
    logic         b_can_take_s;
    logic         accept_s;
    logic         load_a_s;
    logic         load_b_s;
    logic         a_drain_s;
    logic         b_drain_s;

    // Share-local load values; share 1 and share 2 are built in separate cones.
    logic [N-1:0] sh1_load_s;
    logic [N-1:0] sh2_load_s;

    // Handshake decode: a slot can take a word when empty or draining this
    // cycle. in_ready only looks at sel and the slot handshakes, never data.
    always_comb begin
        a_can_take_s = (!a_valid_q) || a_ready;
        b_can_take_s = (!b_valid_q) || b_ready;
        if (sel) begin
            in_ready = b_can_take_s;
        end else begin
            in_ready = a_can_take_s;
        end
        accept_s  = in_valid && in_ready;
        load_a_s  = accept_s && (!sel);
        load_b_s  = accept_s && sel;
        a_drain_s = a_valid_q && a_ready;
        b_drain_s = b_valid_q && b_ready;
    end

`ifdef DEMUX_REFRESH_EN
    // Share refresh: the same mask goes into both shares so their XOR is
    // unchanged; each share only meets rnd, never the other share.
    always_comb begin
        sh1_load_s = in1 ^ rnd;
        sh2_load_s = in2 ^ rnd;
    end
`else
    // Shares pass through unmodified.
    always_comb begin
        sh1_load_s = in1;
        sh2_load_s = in2;
    end
`endif

    // Slot A next state: load on accept, otherwise clear valid on drain.
    // Data registers change only on a load; a drained slot keeps stale data.
    always_comb begin
        a_valid_d = a_valid_q;
        a1_d      = a1_q;
        a2_d      = a2_q;
        if (load_a_s) begin
            a_valid_d = 1'b1;
            a1_d      = sh1_load_s;
            a2_d      = sh2_load_s;
        end else if (a_drain_s) begin
            a_valid_d = 1'b0;
        end else begin
            a_valid_d = a_valid_q;
        end
    end

    // Slot B next state: same rule as slot A, fully independent of it.
    always_comb begin
        b_valid_d = b_valid_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        if (load_b_s) begin
            b_valid_d = 1'b1;
            b1_d      = sh1_load_s;
            b2_d      = sh2_load_s;
        end else if (b_drain_s) begin
            b_valid_d = 1'b0;
        end else begin
            b_valid_d = b_valid_q;
        end
    end

    // State registers; reset wins over any handshake in the same cycle, so a
    // word accepted while rst is high is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a1_q      <= {N{1'b0}};
            a2_q      <= {N{1'b0}};
            b1_q      <= {N{1'b0}};
            b2_q      <= {N{1'b0}};
        end else begin
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
        end
    end

    // Outputs come straight from registers.
    assign a_valid = a_valid_q;
    assign b_valid = b_valid_q;
    assign a1      = a1_q;
    assign a2      = a2_q;
    assign b1      = b1_q;
    assign b2      = b2_q;

endmodule

// File: tb/tb_demux_reg_2sh.sv
// -----------------------------------------------------------------------------
// tb_demux_reg_2sh
//
// Self-checking bench for demux_reg_2sh. A behavioural model keeps, per
// destination, whether a word is waiting and which shares it carries; each
// cycle it predicts in_ready and the registered outputs. Directed steps cover
// reset, single route, backpressure, streaming, concurrent drain/load, reset
// during accept and share refresh, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_demux_reg_2sh;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sel;
    logic [63:0] in1, in2;
    logic        a_valid, a_ready;
    logic [63:0] a1, a2;
    logic        b_valid, b_ready;
    logic [63:0] b1, b2;
    logic [63:0] rnd_v;

    int checks = 0;
    int errors = 0;

    // Model: index 0 = destination A, 1 = destination B.
    logic        m_full [2];
    logic [63:0] m_s1   [2];
    logic [63:0] m_s2   [2];

    demux_reg_2sh #(.N(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .in1      (in1),
        .in2      (in2),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a1       (a1),
        .a2       (a2),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b1       (b1),
        .b2       (b2)
`ifdef DEMUX_REFRESH_EN
        ,
        .rnd      (rnd_v)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready before the edge, advance
    // the model at the edge, then check the registered outputs after it.
    task automatic cyc(input logic r, input logic v, input logic s,
                       input logic [63:0] d1, input logic [63:0] d2,
                       input logic ar, input logic br, input logic [63:0] rn);
        logic       exp_rdy;
        logic       rdy [2];
        logic [63:0] w1, w2;
        rst = r; in_valid = v; sel = s; in1 = d1; in2 = d2;
        a_ready = ar; b_ready = br; rnd_v = rn;
        rdy[0] = ar; rdy[1] = br;
        #1;
        exp_rdy = (!m_full[s]) || rdy[s];
        chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        @(posedge clk);
`ifdef DEMUX_REFRESH_EN
        w1 = d1 ^ rn; w2 = d2 ^ rn;
`else
        w1 = d1; w2 = d2;
`endif
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                m_full[k] = 1'b0; m_s1[k] = 64'd0; m_s2[k] = 64'd0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (v && exp_rdy && (int'(s) == k)) begin
                    m_full[k] = 1'b1; m_s1[k] = w1; m_s2[k] = w2;
                end else if (m_full[k] && rdy[k]) begin
                    m_full[k] = 1'b0;
                end
            end
        end
        #1;
        chk("a_valid", {63'd0, a_valid}, {63'd0, m_full[0]});
        chk("b_valid", {63'd0, b_valid}, {63'd0, m_full[1]});
        chk("a1", a1, m_s1[0]);
        chk("a2", a2, m_s2[0]);
        chk("b1", b1, m_s1[1]);
        chk("b2", b2, m_s2[1]);
    endtask

    initial begin
        logic [63:0] i64;
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 1'b0; m_s1[k] = 64'd0; m_s2[k] = 64'd0;
        end
        rst = 1'b1; in_valid = 1'b0; sel = 1'b0; in1 = 64'd0; in2 = 64'd0;
        a_ready = 1'b0; b_ready = 1'b0; rnd_v = 64'd0;
        @(posedge clk);
        #1;

        // Reset then idle, in_ready high for both sel values.
        cyc(1'b1, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0);
        chk("rst_a_valid", {63'd0, a_valid}, 64'd0);
        chk("rst_b1", b1, 64'd0);
        cyc(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0);
        chk("idle_ready_sel0", {63'd0, in_ready}, 64'd1);
        cyc(1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0);
        chk("idle_ready_sel1", {63'd0, in_ready}, 64'd1);

        // Single route to B, then drain it.
        cyc(1'b0, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0, 64'd0);
        chk("route_b_valid", {63'd0, b_valid}, 64'd1);
        chk("route_a_valid", {63'd0, a_valid}, 64'd0);
        chk("route_b1", b1, 64'h0123_4567_89AB_CDEF);
        chk("route_b2", b2, 64'hFFFF_0000_FFFF_0000);
        cyc(1'b0, 1'b0, 1'b1, 64'd0, 64'd0, 1'b0, 1'b1, 64'd0);
        chk("route_b_drained", {63'd0, b_valid}, 64'd0);
        chk("route_b1_held", b1, 64'h0123_4567_89AB_CDEF);

        // Backpressure on A.
        cyc(1'b0, 1'b1, 1'b0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 1'b0, 64'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0000 + 64'(k), 64'hCAFE_0000_0000_0000, 1'b0, 1'b0, 64'd0);
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            chk("bp_a1_hold", a1, 64'h1111_2222_3333_4444);
            chk("bp_a2_hold", a2, 64'h5555_6666_7777_8888);
        end
        cyc(1'b0, 1'b1, 1'b0, 64'h0BAD_F00D_0000_0001, 64'h0BAD_F00D_0000_0002, 1'b1, 1'b0, 64'd0);
        chk("bp_release_a1", a1, 64'h0BAD_F00D_0000_0001);
        chk("bp_release_valid", {63'd0, a_valid}, 64'd1);

        // Streaming 8 words into A with consumer always ready.
        for (int k = 0; k < 8; k++) begin
            i64 = 64'(k);
            cyc(1'b0, 1'b1, 1'b0, i64, ~i64, 1'b1, 1'b0, 64'd0);
            chk("stream_ready", {63'd0, in_ready}, 64'd1);
            chk("stream_a1", a1, i64);
            chk("stream_a2", a2, ~i64);
            chk("stream_a_valid", {63'd0, a_valid}, 64'd1);
            chk("stream_b_valid", {63'd0, b_valid}, 64'd0);
        end
        cyc(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);
        chk("stream_end", {63'd0, a_valid}, 64'd0);

        // Concurrent: A drains while B loads.
        cyc(1'b0, 1'b1, 1'b0, 64'hA0A0_A0A0_A0A0_A0A0, 64'h0A0A_0A0A_0A0A_0A0A, 1'b0, 1'b0, 64'd0);
        cyc(1'b0, 1'b1, 1'b1, 64'hB0B0_B0B0_B0B0_B0B0, 64'h0B0B_0B0B_0B0B_0B0B, 1'b1, 1'b0, 64'd0);
        chk("conc_a_valid", {63'd0, a_valid}, 64'd0);
        chk("conc_b_valid", {63'd0, b_valid}, 64'd1);
        chk("conc_b1", b1, 64'hB0B0_B0B0_B0B0_B0B0);

        // Reset during an accepting cycle discards the word.
        cyc(1'b1, 1'b1, 1'b1, 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 1'b0, 1'b1, 64'd0);
        chk("rst_acc_a_valid", {63'd0, a_valid}, 64'd0);
        chk("rst_acc_b_valid", {63'd0, b_valid}, 64'd0);
        chk("rst_acc_b1", b1, 64'd0);

        // Share refresh (or plain pass-through without the feature).
        cyc(1'b0, 1'b1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0,
            64'h0F0F_0F0F_0F0F_0F0F);
`ifdef DEMUX_REFRESH_EN
        chk("refresh_a1", a1, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("refresh_a2", a2, 64'h5A5A_5A5A_5A5A_5A5A);
`else
        chk("plain_a1", a1, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("plain_a2", a2, 64'h5555_5555_5555_5555);
`endif
        chk("unmasked", a1 ^ a2, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 39) == 0),
                1'($urandom), 1'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom},
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
